// File: rtl/elevator_pkg.sv
// Shared types and constants for the 5-floor elevator controller.
// Optional build macro ELEV_CANCEL_EN is consumed by elevator_req_latch.
package elevator_pkg;

    localparam int NUM_FLOORS = 5;
    localparam int FLOOR_W    = $clog2(NUM_FLOORS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } ctrlState_t;

    localparam logic [1:0] FIO_STOP = 2'b00;
    localparam logic [1:0] FIO_IN   = 2'b01;
    localparam logic [1:0] FIO_OUT  = 2'b10;
    localparam logic [1:0] FIO_NONE = 2'b11;

    // True when any pending floor lies strictly beyond 'floor' in the given direction.
    function automatic logic anyBeyond(input logic [NUM_FLOORS-1:0] pend,
                                       input logic [FLOOR_W-1:0]    floor,
                                       input logic                  up);
        logic hit;
        hit = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pend[f] && ((up && (FLOOR_W'(f) > floor)) || (!up && (FLOOR_W'(f) < floor))))
                hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/elevator_req_latch.sv
// Button edge detection and pending-request registers (cabin and hall kept apart).
// Define ELEV_CANCEL_EN to make a repeat press on a pending floor cancel it.
module elevator_req_latch
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] inToggle,
    input  logic [NUM_FLOORS-1:0] outToggle,
    input  logic [NUM_FLOORS-1:0] clearMask,
    output logic [NUM_FLOORS-1:0] inPending,
    output logic [NUM_FLOORS-1:0] outPending
);

    logic [NUM_FLOORS-1:0] inPrev, outPrev;
    logic [NUM_FLOORS-1:0] inRise, outRise, pending;
    logic [NUM_FLOORS-1:0] inSet, outSet, cancelMask;
    logic [NUM_FLOORS-1:0] inNext, outNext;

    always_comb begin
        inRise  = inToggle & ~inPrev;
        outRise = outToggle & ~outPrev;
        pending = inPending | outPending;
`ifdef ELEV_CANCEL_EN
        // A press on an already-pending floor withdraws it; a double rise counts once.
        cancelMask = (inRise | outRise) & pending;
        inSet      = inRise & ~pending;
        outSet     = outRise & ~pending;
`else
        cancelMask = '0;
        inSet      = inRise;
        outSet     = outRise;
`endif
        // Only the served door floor overrides a simultaneous press.
        inNext  = ((inPending & ~cancelMask) | inSet) & ~clearMask;
        outNext = ((outPending & ~cancelMask) | outSet) & ~clearMask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inPrev     <= '0;
            outPrev    <= '0;
            inPending  <= '0;
            outPending <= '0;
        end else begin
            inPrev     <= inToggle;
            outPrev    <= outToggle;
            inPending  <= inNext;
            outPending <= outNext;
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// 5-floor collective (SCAN) elevator controller: IDLE/MOVE/DOOR FSM, travel and
// door counters, per-floor status decode. Build macro ELEV_CANCEL_EN enables press-to-cancel.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOOR_CYCLES = 4,
    parameter int DOOR_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] InToggle,
    input  logic [NUM_FLOORS-1:0] OutToggle,
    output logic [NUM_FLOORS-1:0] PushedButtons,
    output logic [NUM_FLOORS-1:0] WhichFloor,
    output logic                  Process,
    output logic                  Dir,
    output logic [1:0]            FloorInOut [NUM_FLOORS-1:0]
);

    localparam int CNT_MAX = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   FLOOR_LAST = CNT_W'(FLOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST  = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    ctrlState_t            state, nextState;
    logic [FLOOR_W-1:0]    curFloor, nextFloor, stepFloor;
    logic                  nextDir;
    logic [CNT_W-1:0]      cycleCnt, nextCnt;
    logic [NUM_FLOORS-1:0] inPending, outPending, pending, clearMask;
    logic [NUM_FLOORS-1:0] curOneHot, stepOneHot;

    elevator_req_latch reqLatch (
        .clk       (clk),
        .rst       (rst),
        .inToggle  (InToggle),
        .outToggle (OutToggle),
        .clearMask (clearMask),
        .inPending (inPending),
        .outPending(outPending)
    );

    assign pending    = inPending | outPending;
    assign curOneHot  = NUM_FLOORS'(1) << curFloor;
    assign stepOneHot = NUM_FLOORS'(1) << stepFloor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            curFloor <= '0;
            Dir      <= 1'b1;
            cycleCnt <= '0;
        end else begin
            state    <= nextState;
            curFloor <= nextFloor;
            Dir      <= nextDir;
            cycleCnt <= nextCnt;
        end
    end

    always_comb begin
        nextState = state;
        nextFloor = curFloor;
        nextDir   = Dir;
        nextCnt   = cycleCnt;
        if (Dir && (curFloor != TOP_FLOOR))
            stepFloor = curFloor + 1'b1;
        else if (!Dir && (curFloor != '0))
            stepFloor = curFloor - 1'b1;
        else
            stepFloor = curFloor;

        case (state)
            IDLE: begin
                nextCnt = '0;
                if ((pending & curOneHot) != '0) begin
                    nextState = DOOR;
                end else if (pending != '0) begin
                    // Keep sweeping while work remains ahead, otherwise turn around.
                    nextDir   = anyBeyond(pending, curFloor, Dir) ? Dir : !Dir;
                    nextState = MOVE;
                end
            end
            MOVE: begin
                if (cycleCnt == FLOOR_LAST) begin
                    nextCnt   = '0;
                    nextFloor = stepFloor;
                    if (stepFloor == TOP_FLOOR)
                        nextDir = 1'b0;
                    else if (stepFloor == '0)
                        nextDir = 1'b1;
                    if ((pending & stepOneHot) != '0)
                        nextState = DOOR;
                    else if (anyBeyond(pending, stepFloor, Dir))
                        nextState = MOVE;
                    else
                        nextState = IDLE;
                end else begin
                    nextCnt = cycleCnt + 1'b1;
                end
            end
            DOOR: begin
                if (cycleCnt == DOOR_LAST) begin
                    nextCnt   = '0;
                    nextState = IDLE;
                end else begin
                    nextCnt = cycleCnt + 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
                nextCnt   = '0;
            end
        endcase
    end

    always_comb begin
        WhichFloor    = curOneHot;
        Process       = (state == MOVE);
        PushedButtons = pending;
        // Clear the served floor on the edge entering DOOR and for every DOOR cycle.
        clearMask = '0;
        if (nextState == DOOR)
            clearMask = NUM_FLOORS'(1) << nextFloor;
        if (state == DOOR)
            clearMask = clearMask | curOneHot;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (curOneHot[f] && (state != MOVE))
                FloorInOut[f] = FIO_STOP;
            else if (inPending[f])
                FloorInOut[f] = FIO_IN;
            else if (outPending[f])
                FloorInOut[f] = FIO_OUT;
            else
                FloorInOut[f] = FIO_NONE;
        end
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed self-checking bench for elevator_ctrl (FLOOR_CYCLES=4, DOOR_CYCLES=2).
// Expectations for the repeat-press step follow the ELEV_CANCEL_EN build setting.
module tb_elevator_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] InToggle;
    logic [4:0] OutToggle;
    logic [4:0] PushedButtons;
    logic [4:0] WhichFloor;
    logic       Process;
    logic       Dir;
    logic [1:0] FloorInOut [4:0];

    int checks   = 0;
    int failures = 0;

    elevator_ctrl #(.FLOOR_CYCLES(4), .DOOR_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .InToggle     (InToggle),
        .OutToggle    (OutToggle),
        .PushedButtons(PushedButtons),
        .WhichFloor   (WhichFloor),
        .Process      (Process),
        .Dir          (Dir),
        .FloorInOut   (FloorInOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        InToggle = '0;
        OutToggle = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_pushed", 8'(PushedButtons), 8'b00000);
        chk("rst_floor",  8'(WhichFloor),    8'b00001);
        chk("rst_proc",   8'(Process),       8'd0);
        chk("rst_dir",    8'(Dir),           8'd1);
        chk("rst_fio0",   8'(FloorInOut[0]), 8'b00);
        chk("rst_fio1",   8'(FloorInOut[1]), 8'b11);

        // Hall call at the current floor: latched one cycle, then served in place.
        OutToggle = 5'b00001;
        tick(1);
        chk("a_pushed1", 8'(PushedButtons), 8'b00001);
        chk("a_proc1",   8'(Process),       8'd0);
        chk("a_fio0",    8'(FloorInOut[0]), 8'b00);
        OutToggle = '0;
        tick(1);
        chk("a_pushed2", 8'(PushedButtons), 8'b00000);
        chk("a_proc2",   8'(Process),       8'd0);
        chk("a_fio0b",   8'(FloorInOut[0]), 8'b00);
        tick(3);
        chk("a_proc3",   8'(Process),       8'd0);

        // Cabin call to floor 2 from floor 0.
        InToggle = 5'b00100;
        tick(1);
        chk("b_pushed", 8'(PushedButtons), 8'b00100);
        chk("b_fio2in", 8'(FloorInOut[2]), 8'b01);
        chk("b_proc0",  8'(Process),       8'd0);
        InToggle = '0;
        tick(1);
        chk("b_proc1",  8'(Process),       8'd1);
        chk("b_dir",    8'(Dir),           8'd1);
        chk("b_floor0", 8'(WhichFloor),    8'b00001);
        chk("b_fio0mv", 8'(FloorInOut[0]), 8'b11);
        tick(3);
        chk("b_floor0b", 8'(WhichFloor),   8'b00001);
        tick(1);
        chk("b_floor1", 8'(WhichFloor),    8'b00010);
        chk("b_proc2",  8'(Process),       8'd1);
        tick(4);
        chk("b_floor2", 8'(WhichFloor),    8'b00100);
        chk("b_proc3",  8'(Process),       8'd0);
        chk("b_pushed2", 8'(PushedButtons), 8'b00000);
        chk("b_fio2st", 8'(FloorInOut[2]), 8'b00);
        chk("b_dir2",   8'(Dir),           8'd1);
        tick(2);

        // Hall calls above and below at once: up first, then reverse.
        OutToggle = 5'b01010;
        tick(1);
        chk("c_pushed", 8'(PushedButtons), 8'b01010);
        chk("c_fio1",   8'(FloorInOut[1]), 8'b10);
        chk("c_fio3",   8'(FloorInOut[3]), 8'b10);
        OutToggle = '0;
        tick(1);
        chk("c_proc1", 8'(Process), 8'd1);
        chk("c_dir1",  8'(Dir),     8'd1);
        tick(4);
        chk("c_floor3",  8'(WhichFloor),    8'b01000);
        chk("c_proc2",   8'(Process),       8'd0);
        chk("c_pushed2", 8'(PushedButtons), 8'b00010);
        tick(3);
        chk("c_proc3",  8'(Process),    8'd1);
        chk("c_dir2",   8'(Dir),        8'd0);
        chk("c_floor3b", 8'(WhichFloor), 8'b01000);
        tick(8);
        chk("c_floor1",  8'(WhichFloor),    8'b00010);
        chk("c_pushed3", 8'(PushedButtons), 8'b00000);
        chk("c_proc4",   8'(Process),       8'd0);
        chk("c_dir3",    8'(Dir),           8'd0);
        tick(2);

        // Asynchronous reset while travelling.
        InToggle = 5'b10000;
        tick(1);
        chk("r_pushed", 8'(PushedButtons), 8'b10000);
        InToggle = '0;
        tick(1);
        chk("r_proc", 8'(Process), 8'd1);
        chk("r_dir",  8'(Dir),     8'd1);
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        chk("r_pushed0", 8'(PushedButtons), 8'b00000);
        chk("r_floor0",  8'(WhichFloor),    8'b00001);
        chk("r_proc0",   8'(Process),       8'd0);
        chk("r_dir0",    8'(Dir),           8'd1);
        chk("r_fio0",    8'(FloorInOut[0]), 8'b00);
        chk("r_fio4",    8'(FloorInOut[4]), 8'b11);
        rst = 1'b0;
        tick(1);
        chk("r_proc1",   8'(Process),       8'd0);
        chk("r_pushed1", 8'(PushedButtons), 8'b00000);

        // Trip 0->4 with an intermediate cabin call to floor 2 added en route.
        InToggle = 5'b10000;
        tick(1);
        chk("d_fio4in", 8'(FloorInOut[4]), 8'b01);
        InToggle = '0;
        tick(5);
        chk("d_floor1", 8'(WhichFloor), 8'b00010);
        chk("d_proc1",  8'(Process),    8'd1);
        InToggle = 5'b00100;
        tick(1);
        InToggle = '0;
        chk("d_pushed1", 8'(PushedButtons), 8'b10100);
        chk("d_fio2in",  8'(FloorInOut[2]), 8'b01);
        tick(3);
        chk("d_floor2",  8'(WhichFloor),    8'b00100);
        chk("d_proc2",   8'(Process),       8'd0);
        chk("d_pushed2", 8'(PushedButtons), 8'b10000);
        chk("d_fio4in2", 8'(FloorInOut[4]), 8'b01);
        chk("d_fio2st",  8'(FloorInOut[2]), 8'b00);
        tick(1);
        chk("d_door1", 8'(Process), 8'd0);
        tick(1);
        chk("d_idle",  8'(Process), 8'd0);
        tick(1);
        chk("d_proc3", 8'(Process), 8'd1);
        tick(7);
        chk("d_floor3",  8'(WhichFloor),    8'b01000);
        chk("d_fio4in3", 8'(FloorInOut[4]), 8'b01);
        tick(1);
        chk("d_floor4",  8'(WhichFloor),    8'b10000);
        chk("d_proc4",   8'(Process),       8'd0);
        chk("d_pushed3", 8'(PushedButtons), 8'b00000);
        chk("d_dir4",    8'(Dir),           8'd0);
        chk("d_fio4st",  8'(FloorInOut[4]), 8'b00);
        tick(2);

        // Repeat press on a pending floor, second press held for two cycles.
        InToggle = 5'b00001;
        tick(1);
        chk("e_pushed1", 8'(PushedButtons), 8'b00001);
        InToggle = '0;
        tick(1);
        chk("e_proc1", 8'(Process), 8'd1);
        chk("e_dir1",  8'(Dir),     8'd0);
        InToggle = 5'b00001;
        tick(1);
`ifdef ELEV_CANCEL_EN
        chk("e_pushed2", 8'(PushedButtons), 8'b00000);
        tick(1);
        chk("e_pushed3", 8'(PushedButtons), 8'b00000);
        InToggle = '0;
        tick(2);
        chk("e_floor3", 8'(WhichFloor), 8'b01000);
        chk("e_proc2",  8'(Process),    8'd0);
        tick(2);
        chk("e_proc3",   8'(Process),       8'd0);
        chk("e_pushed4", 8'(PushedButtons), 8'b00000);
        chk("e_fio3st",  8'(FloorInOut[3]), 8'b00);
`else
        chk("e_pushed2", 8'(PushedButtons), 8'b00001);
        tick(1);
        chk("e_pushed3", 8'(PushedButtons), 8'b00001);
        InToggle = '0;
        tick(2);
        chk("e_floor3", 8'(WhichFloor), 8'b01000);
        chk("e_proc2",  8'(Process),    8'd1);
        tick(12);
        chk("e_floor0",  8'(WhichFloor),    8'b00001);
        chk("e_pushed4", 8'(PushedButtons), 8'b00000);
        chk("e_dir0",    8'(Dir),           8'd1);
        chk("e_proc3",   8'(Process),       8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
